// File: rtl/img_line_buffer_if.sv
// Pixel stream handshake bundle between an upstream source and the line buffer.
//   s_axis_tdata  : pixel payload (source -> buffer)
//   s_axis_tvalid : payload valid (source -> buffer)
//   s_axis_tready : buffer can accept a pixel (buffer -> source)
interface img_line_buffer_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready
  );
endinterface

// File: rtl/img_line_buffer.sv
// One-line delay buffer for a raster-order square image. Each accepted pixel
// is re-emitted exactly one image line later; the last line of a frame is
// drained autonomously while the input is held off.
//   clk, rst      : clock and synchronous active-high reset
//   s_if          : pixel input handshake (slave side)
//   IMG_SIZE_I    : image width = height, sampled on the first pixel of a frame
//   data_o        : delayed pixel
//   data_valid_o  : one-cycle pulse per delayed pixel
module img_line_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_W  = 512,
  parameter int unsigned SIZE_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  img_line_buffer_if.slave  s_if,
  input  logic [SIZE_W-1:0] IMG_SIZE_I,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o
);

  localparam int unsigned PTR_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam int unsigned PROD_W = 2 * SIZE_W;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t              state_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [SIZE_W-1:0]   fill_q;
  logic [PROD_W-1:0]   frame_q;
  logic [SIZE_W-1:0]   size_q;
  logic                tready_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;

  logic [DATA_W-1:0]   mem [MAX_W];

  logic                size_ok;
  logic                wr_fire;
  logic                rd_en;
  logic [SIZE_W-1:0]   size_eff;
  logic [PROD_W-1:0]   frame_d;
  logic                frame_end;
  logic                drain_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_W - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Strobes and frame bookkeeping; the size input only matters until latched.
  always_comb begin
    size_ok    = 1'b0;
    wr_fire    = 1'b0;
    rd_en      = 1'b0;
    size_eff   = size_q;
    frame_d    = frame_q + PROD_W'(1);
    frame_end  = 1'b0;
    drain_next = 1'b0;

    if (frame_q == '0) begin
      size_eff = IMG_SIZE_I;
    end
    // A zero size can only block the start of a frame; mid-frame it is ignored.
    size_ok   = (frame_q != '0) || (IMG_SIZE_I != '0);
    wr_fire   = s_if.s_axis_tvalid & tready_q & size_ok;
    frame_end = wr_fire && (frame_d == PROD_W'(size_eff) * PROD_W'(size_eff));

    case (state_q)
      FILL:    rd_en = 1'b0;
      STREAM:  rd_en = wr_fire;
      DRAIN:   rd_en = 1'b1;
      default: rd_en = 1'b0;
    endcase

    // Used to drop tready on the same edge the state enters or stays in DRAIN.
    if (state_q == DRAIN) begin
      drain_next = (fill_q != SIZE_W'(1));
    end else begin
      drain_next = frame_end;
    end
  end

  assign s_if.s_axis_tready = tready_q & size_ok;
  assign data_o             = data_q;
  assign data_valid_o       = valid_q;

  // Line storage; reads and writes never target the same word in one cycle.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_q] <= s_if.s_axis_tdata;
    end
  end

  // Control FSM, pointers, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      frame_q  <= '0;
      size_q   <= '0;
      tready_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      tready_q <= ~drain_next;
      valid_q  <= rd_en;

      if (rd_en) begin
        data_q   <= mem[rd_ptr_q];
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end

      if (wr_fire) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        frame_q  <= frame_d;
        if (frame_q == '0) begin
          size_q <= IMG_SIZE_I;
        end
      end

      case (state_q)
        FILL: begin
          if (wr_fire) begin
            fill_q <= fill_q + SIZE_W'(1);
            // Frame end wins when a one-pixel line completes the frame.
            if (frame_end) begin
              state_q <= DRAIN;
            end else if (fill_q + SIZE_W'(1) == size_eff) begin
              state_q <= STREAM;
            end
          end
        end
        STREAM: begin
          if (frame_end) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          fill_q <= fill_q - SIZE_W'(1);
          if (fill_q == SIZE_W'(1)) begin
            state_q <= FILL;
            frame_q <= '0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_img_line_buffer.sv
// Self-checking bench for img_line_buffer: per-scenario tasks plus a
// scoreboard monitor that pairs every output pulse with the accepted input.
module tb_img_line_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] img_size = 9'd5;
  logic [7:0] data_o;
  logic       data_valid;

  int checks  = 0;
  int errors  = 0;
  int out_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  img_line_buffer_if #(.DATA_W(8)) bus ();

  img_line_buffer #(.DATA_W(8), .MAX_W(512), .SIZE_W(9)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_if         (bus),
    .IMG_SIZE_I   (img_size),
    .data_o       (data_o),
    .data_valid_o (data_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every valid pulse must match the oldest accepted pixel.
  always @(posedge clk) begin
    #1;
    if (!rst && data_valid === 1'b1) begin
      out_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_extra: data_o=%0d with nothing expected", data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (data_o !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard_data: data_o=%0d, required %0d", data_o, mon_exp);
        end
      end
    end
  end

  // Present one pixel; waits (bounded) for tready, leaves tvalid high.
  task automatic send(input logic [7:0] d);
    int w = 0;
    @(negedge clk);
    while (bus.s_axis_tready !== 1'b1 && w < 64) begin
      bus.s_axis_tvalid = 1'b0;
      @(negedge clk);
      w++;
    end
    if (w >= 64) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tready=%b, required 1", bus.s_axis_tready);
      bus.s_axis_tvalid = 1'b0;
      return;
    end
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    exp_q.push_back(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    img_size = 9'd5;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    repeat (5) @(negedge clk);
    checks++;
    if (bus.s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tready_during: tready=%b, required 0", bus.s_axis_tready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b0 || data_o !== 8'd0 || bus.s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%0d tready=%b, required 0 0 1",
               data_valid, data_o, bus.s_axis_tready);
    end
  endtask

  // Back-to-back frame of s*s pixels base.. then check the autonomous drain.
  task automatic run_frame(input int s, input int base);
    int n  = s * s;
    int f0 = out_cnt;
    int want;
    img_size = 9'(s);
    for (int i = 1; i <= n; i++) begin
      send(8'(base + i - 1));
      want = (i - 1 - s > 0) ? (i - 1 - s) : 0;
      checks++;
      if (out_cnt - f0 !== want) begin
        errors++;
        $display("FAIL frame_out_count: s=%0d pixel %0d outputs=%0d, required %0d",
                 s, i, out_cnt - f0, want);
      end
      if (i == s + 2) begin
        checks++;
        if (data_valid !== 1'b1 || data_o !== 8'(base)) begin
          errors++;
          $display("FAIL first_output: valid=%b data=%0d, required 1 %0d",
                   data_valid, data_o, base);
        end
      end
    end
    for (int c = 0; c <= s; c++) begin
      @(negedge clk);
      bus.s_axis_tvalid = 1'b0;
      checks++;
      if (bus.s_axis_tready !== (c == s)) begin
        errors++;
        $display("FAIL drain_tready: s=%0d cycle %0d tready=%b, required %0d",
                 s, c, bus.s_axis_tready, (c == s));
      end
      if (c >= 1) begin
        checks++;
        if (data_valid !== 1'b1 || data_o !== 8'(base + n - s + c - 1)) begin
          errors++;
          $display("FAIL drain_data: s=%0d cycle %0d valid=%b data=%0d, required 1 %0d",
                   s, c, data_valid, data_o, base + n - s + c - 1);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (data_valid !== 1'b0 || out_cnt - f0 !== n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_total: valid=%b outputs=%0d pending=%0d, required 0 %0d 0",
               data_valid, out_cnt - f0, exp_q.size(), n);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(5, 1);
  endtask

  task automatic test_gappy(input int s, input int base);
    int n  = s * s;
    int f0 = out_cnt;
    int w  = 0;
    int want;
    img_size = 9'(s);
    for (int i = 1; i <= n; i++) begin
      send(8'(base + i - 1));
      if (i > 1) begin
        checks++;
        if (data_valid !== 1'b0) begin
          errors++;
          $display("FAIL gappy_idle_valid: pixel %0d valid=%b, required 0", i, data_valid);
        end
      end
      @(negedge clk);
      bus.s_axis_tvalid = 1'b0;
      want = (i - s > 0) ? (i - s) : 0;
      checks++;
      if (out_cnt - f0 !== want) begin
        errors++;
        $display("FAIL gappy_out_count: pixel %0d outputs=%0d, required %0d",
                 i, out_cnt - f0, want);
      end
    end
    while (bus.s_axis_tready !== 1'b1 && w < 64) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (w >= 64 || out_cnt - f0 !== n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL gappy_total: outputs=%0d pending=%0d waited=%0d, required %0d 0",
               out_cnt - f0, exp_q.size(), w, n);
    end
  endtask

  task automatic test_second_frame();
    run_frame(3, 100);
  endtask

  task automatic test_reset_mid();
    int f0 = out_cnt;
    int held;
    img_size = 9'd5;
    for (int i = 1; i <= 8; i++) send(8'(i + 10));
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    rst = 1'b1;
    checks++;
    if (out_cnt - f0 !== 3) begin
      errors++;
      $display("FAIL midreset_pre: outputs=%0d, required 3", out_cnt - f0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    held = out_cnt;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (data_valid !== 1'b0 || out_cnt !== held) begin
        errors++;
        $display("FAIL midreset_quiet: valid=%b outputs=%0d, required 0 %0d",
                 data_valid, out_cnt, held);
      end
    end
    run_frame(5, 1);
  endtask

  task automatic test_size_one();
    for (int k = 0; k < 3; k++) run_frame(1, 200 + k);
  endtask

  initial begin
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    test_reset();
    test_back_to_back();
    test_gappy(5, 50);
    test_second_frame();
    test_reset_mid();
    test_size_one();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
